mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the unified instruction/data memory for the multicycle RV32 core.
- Sits between the multicycle controller/datapath and the word-only memory. The memory has combinational read, synchronous write on MemWrite, and word addressing via A[31:2].
- Supports RV32 byte, halfword and word loads and stores. Loads are sign- or zero-extended. Sub-word stores use a read-modify-write sequence, because the memory only writes full words.
- Uses a req/ready/done handshake toward the controller.

Parameters:
- MEM_SIZE, 64, memory depth in words. The word index driven to memory is addr[31:2] % MEM_SIZE.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  1  access request, sampled only when ready=1
- we  in  1  1=store, 0=load; sampled with req
- funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address, sampled with req
- wdata  in  32  store data; the low byte/half/word is used, sampled with req
- ready  out  1  high in IDLE only
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, registered, held until the next load completes
- misalign  out  1  valid with done; access was suppressed
- mem_A  out  32  memory address {word_index, 2'b00}
- mem_WD  out  32  memory write data
- mem_MemWrite  out  1  memory write enable
- mem_RD  in  32  memory read data (combinational)

Behaviour:
- Reset values: state IDLE, ready=1, done=0, rdata=0, misalign=0, mem_MemWrite=0, mem_A=0, mem_WD=0.
  - Reset aborts any access in flight; no write is issued in the reset cycle or afterwards.
- States: IDLE, LOAD, RMW_READ, WRITE, DONE.
- IDLE, on req=1: latch we, funct3, addr and wdata, then branch:
  - Illegal code (funct3 = 011/110/111, or a store with funct3[2]=1) -> DONE. rdata is unchanged, misalign=0, no memory access.
  - Misaligned (W with addr[1:0]!=0; H/HU with addr[0]=1) -> DONE with misalign=1. No write; rdata unchanged.
  - Load -> LOAD.
  - SW -> WRITE.
  - SB or SH -> RMW_READ.
- req while not in IDLE is ignored; the controller must wait for ready.
- LOAD (one cycle):
  - Drive mem_A from the latched address.
  - At the clock edge, register the extracted lane of mem_RD into rdata. The lane is selected by addr[1:0], little-endian.
  - B/H are sign-extended; BU/HU are zero-extended.
  - Next state DONE.
- RMW_READ (one cycle): drive mem_A; at the edge, capture mem_RD into an internal word buffer; next state WRITE.
- WRITE (one cycle): assert mem_MemWrite=1 and drive mem_A. Next state DONE.
  - SW: mem_WD=wdata.
  - SB: buffer with byte addr[1:0] replaced by wdata[7:0].
  - SH: buffer with half addr[1] replaced by wdata[15:0].
- DONE: done=1 for exactly one cycle, then IDLE. misalign is meaningful only while done=1 and is cleared on return to IDLE.
- Latency from the req-accept edge to the done-high cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - misaligned or illegal: 1 cycle
- mem_MemWrite is high only in WRITE, and for exactly one cycle per store.
- Address wrap: word index = addr[31:2] % MEM_SIZE, so address 0x100 with MEM_SIZE=64 maps to word 0.
- Outside LOAD/RMW_READ/WRITE, mem_A holds its last value and mem_WD is don't-care. mem_MemWrite must be 0 outside WRITE.

Optional Feature:
- MAU_MISALIGN_CHECK_EN defined: misalignment detection and suppression behave as above.
- Not defined: misalign is tied to 0. Low address bits below the access width are ignored: a word access uses addr[1:0]=00 and a half access uses addr[0]=0. The access then proceeds normally.

Decomposition:
- Shared package holds:
  - the state enum
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the RMW byte-lane merge function
- One natural sub-module, mau_lane_extract: combinational lane select plus sign/zero extension from (word, addr[1:0], funct3) to 32 bits. It is reused by the load path.

Test Plan:
- Memory word 0x10 preloaded with 0x8899AABB. LB addr 0x11 -> done 2 cycles after accept, rdata=0xFFFFFFAA, mem_MemWrite never high.
- Same word. LBU 0x13 -> rdata=0x00000088. LH 0x12 -> rdata=0xFFFF8899. LHU 0x10 -> rdata=0x0000AABB.
- SB addr 0x12, wdata=0x12345655 -> one-cycle mem_MemWrite with mem_WD=0x8855AABB; done 3 cycles after accept; readback LW returns 0x8855AABB.
- With MAU_MISALIGN_CHECK_EN: SH addr 0x13 -> done+misalign next cycle, no write, memory unchanged. Without the macro: writes half at 0x12.
- SW addr 0x104, wdata=0xDEADBEEF, MEM_SIZE=64 -> mem_A=0x004, word 1 = 0xDEADBEEF.
- Reset asserted during RMW_READ of an SB -> mem_MemWrite stays 0, the next cycle shows ready=1 with done=0, and memory is unchanged.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types, funct3 width codes and the sub-word store merge helper
// for the multicycle core's memory access unit.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRead,
    StWrite,
    StDone
  } mau_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Replace the addressed byte/half of a full memory word with store data.
  function automatic logic [31:0] rmw_merge(input logic [31:0] mem_word,
                                            input logic [1:0]  addr_lo,
                                            input logic [2:0]  funct3,
                                            input logic [31:0] store_data);
    logic [31:0] res;
    res = mem_word;
    case (funct3[1:0])
      2'b00: begin
        case (addr_lo)
          2'd0:    res[7:0]   = store_data[7:0];
          2'd1:    res[15:8]  = store_data[7:0];
          2'd2:    res[23:16] = store_data[7:0];
          default: res[31:24] = store_data[7:0];
        endcase
      end
      2'b01: begin
        if (addr_lo[1]) res[31:16] = store_data[15:0];
        else            res[15:0]  = store_data[15:0];
      end
      default: res = store_data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mau_lane_extract.sv
// Load lane selection: picks the little-endian byte/half/word addressed by
// addr_lo_i out of a memory word and sign- or zero-extends it to 32 bits.
module mau_lane_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane mux followed by extension chosen by the width code.
  always_comb begin
    byte_lane = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_lane = word_i[7:0];
      2'd1:    byte_lane = word_i[15:8];
      2'd2:    byte_lane = word_i[23:16];
      default: byte_lane = word_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   data_o = {24'h000000, byte_lane};
      F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   data_o = {16'h0000, half_lane};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: initiator toward a word-only unified memory. Handles
// byte/half/word loads with extension and sub-word stores by read-modify-write.
// Optional feature macro: MAU_MISALIGN_CHECK_EN (misaligned accesses are
// suppressed and flagged; when undefined, low address bits are ignored).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_MemWrite,
  input  logic [31:0] mem_RD
);

  mau_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic [31:0] mem_a_q, mem_a_d;

  logic        illegal;
  logic        misaligned;
  logic [31:0] addr_eff;
  logic [29:0] word_idx;
  logic [31:0] lane_data;

  // Classify the incoming request and form the effective word address.
  always_comb begin
    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
              (we && funct3[2]);
    addr_eff = addr;
`ifdef MAU_MISALIGN_CHECK_EN
    misaligned = ((funct3 == F3_W) && (addr[1:0] != 2'b00)) ||
                 (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]);
`else
    misaligned = 1'b0;
    if (funct3 == F3_W) begin
      addr_eff[1:0] = 2'b00;
    end else if ((funct3 == F3_H) || (funct3 == F3_HU)) begin
      addr_eff[0] = 1'b0;
    end
`endif
    word_idx = 30'(addr_eff[31:2] % MEM_SIZE);
  end

  mau_lane_extract u_lane_extract (
    .word_i    (mem_RD),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (lane_data)
  );

  // Next-state logic for the access sequencer and its latched request.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    mem_a_d    = mem_a_q;

    case (state_q)
      StIdle: begin
        if (req) begin
          we_d      = we;
          funct3_d  = funct3;
          addr_lo_d = addr_eff[1:0];
          wdata_d   = wdata;
          if (illegal) begin
            misalign_d = 1'b0;
            state_d    = StDone;
          end else if (misaligned) begin
            misalign_d = 1'b1;
            state_d    = StDone;
          end else begin
            misalign_d = 1'b0;
            // mem_A only moves when a real access starts.
            mem_a_d    = {word_idx, 2'b00};
            if (!we) begin
              state_d = StLoad;
            end else if (funct3 == F3_W) begin
              state_d = StWrite;
            end else begin
              state_d = StRmwRead;
            end
          end
        end
      end
      StLoad: begin
        rdata_d = lane_data;
        state_d = StDone;
      end
      StRmwRead: begin
        buf_d   = mem_RD;
        state_d = StWrite;
      end
      StWrite: begin
        state_d = StDone;
      end
      StDone: begin
        misalign_d = 1'b0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      wdata_q    <= 32'h0;
      buf_q      <= 32'h0;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
      mem_a_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      mem_a_q    <= mem_a_d;
    end
  end

  // Memory-side outputs; the write strobe is gated by reset so an aborted
  // store never reaches memory.
  always_comb begin
    mem_WD       = 32'h0;
    mem_MemWrite = 1'b0;
    if (state_q == StWrite) begin
      mem_WD       = rmw_merge(buf_q, addr_lo_q, funct3_q, wdata_q);
      mem_MemWrite = !reset;
    end
  end

  assign mem_A    = mem_a_q;
  assign ready    = (state_q == StIdle);
  assign done     = (state_q == StDone);
  assign rdata    = rdata_q;
  assign misalign = misalign_q;

  // we_q is kept for visibility of the latched request.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random
// accesses compared against a byte-level reference memory model.
module tb_mem_access_unit;

  localparam int unsigned MemSize = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_MemWrite;
  logic [31:0] mem_RD;

  logic [31:0] env_mem [MemSize];
  logic [31:0] ref_mem [MemSize];
  logic [31:0] ref_rdata;

  int unsigned wr_cnt = 0;
  logic [31:0] last_wa = 32'h0;
  logic [31:0] last_wd = 32'h0;
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_SIZE(MemSize)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .ready        (ready),
    .done         (done),
    .rdata        (rdata),
    .misalign     (misalign),
    .mem_A        (mem_A),
    .mem_WD       (mem_WD),
    .mem_MemWrite (mem_MemWrite),
    .mem_RD       (mem_RD)
  );

  // Word-only memory: combinational read, synchronous write.
  assign mem_RD = env_mem[mem_A[7:2]];

  always @(posedge clk) begin
    if (pre_en) begin
      env_mem[pre_idx] <= pre_data;
    end else if (mem_MemWrite) begin
      env_mem[mem_A[7:2]] <= mem_WD;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_A;
      last_wd <= mem_WD;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_idx  = 6'(idx);
    pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Issue one access, predict its outcome from the ISA rules and compare.
  task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
    logic        illegal;
    logic        exp_mis;
    int          size;
    int          sh;
    int          exp_lat;
    int          exp_wr;
    int          idx;
    int          lat;
    int          guard;
    int unsigned wr0;
    logic [31:0] ea;
    logic [31:0] v;
    logic [63:0] m;

    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w && f3[2]);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ea = a;
    exp_mis = 1'b0;
    if (!illegal) begin
`ifdef MAU_MISALIGN_CHECK_EN
      exp_mis = (a % size) != 0;
`else
      ea = a - (a % size);
`endif
    end
    idx = int'((ea >> 2) % MemSize);
    sh  = 8 * int'(ea % 4);
    exp_wr = 0;
    if (illegal || exp_mis) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat = 2;
      v = ref_mem[idx] >> sh;
      if (size == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end
      ref_rdata = v;
    end else begin
      exp_wr  = 1;
      exp_lat = (size == 4) ? 2 : 3;
      m = ((64'd1 << (8 * size)) - 64'd1) << sh;
      ref_mem[idx] = (ref_mem[idx] & ~m[31:0]) | ((d << sh) & m[31:0]);
    end

    wr0 = wr_cnt;
    @(negedge clk);
    guard = 0;
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", 32'(ready), 32'd1);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    @(posedge clk);
    #1;
    // Scramble inputs so only latched values can be used.
    req = 1'b0;
    we = 1'($urandom_range(0, 1));
    funct3 = 3'($urandom_range(0, 7));
    addr = $urandom;
    wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 10);
    check("latency", 32'(lat), 32'(exp_lat));
    check("misalign", 32'(misalign), 32'(exp_mis));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("misalign_clear", 32'(misalign), 32'd0);
    check("rdata", rdata, ref_rdata);
    check("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_wr == 1) begin
      check("write_addr", last_wa, 32'(idx << 2));
    end
    check("mem_word", env_mem[idx], ref_mem[idx]);
  endtask

  // Reset a byte store after 'stall' cycles (1 = RMW_READ, 2 = WRITE).
  task automatic reset_mid_store(input int stall, input logic [31:0] a, input logic [31:0] d);
    int unsigned wr0;
    int          idx;
    idx = int'((a >> 2) % MemSize);
    wr0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (stall) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_no_write_strobe", 32'(mem_MemWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_rdata = 32'h0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    check("rst_write_count", 32'(wr_cnt - wr0), 32'd0);
    check("rst_mem_word", env_mem[idx], ref_mem[idx]);
    check("rst_strobe_idle", 32'(mem_MemWrite), 32'd0);
  endtask

  initial begin
    logic        rw;
    logic [2:0]  rf3;
    logic [31:0] ra;

    reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    pre_en = 1'b0; pre_idx = 6'd0; pre_data = 32'h0; ref_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_misalign", 32'(misalign), 32'd0);
    check("reset_memwrite", 32'(mem_MemWrite), 32'd0);
    check("reset_mem_A", mem_A, 32'h0);
    check("reset_mem_WD", mem_WD, 32'h0);
    for (int i = 0; i < int'(MemSize); i++) preload(i, $urandom);
    preload(4, 32'h8899AABB);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases on word 0x10.
    do_access(1'b0, 3'b000, 32'h11, 32'h0);
    check("lb_value", rdata, 32'hFFFFFFAA);
    do_access(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_value", rdata, 32'h00000088);
    do_access(1'b0, 3'b001, 32'h12, 32'h0);
    check("lh_value", rdata, 32'hFFFF8899);
    do_access(1'b0, 3'b101, 32'h10, 32'h0);
    check("lhu_value", rdata, 32'h0000AABB);
    do_access(1'b1, 3'b000, 32'h12, 32'h12345655);
    check("sb_wd", last_wd, 32'h8855AABB);
    do_access(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_readback", rdata, 32'h8855AABB);
    do_access(1'b1, 3'b001, 32'h13, 32'h0000C3D4);
    do_access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
    check("sw_wrap_addr", last_wa, 32'h4);
    check("sw_wrap_word", env_mem[1], 32'hDEADBEEF);
    do_access(1'b0, 3'b011, 32'h10, 32'h0);
    do_access(1'b1, 3'b100, 32'h10, 32'h55);
    do_access(1'b0, 3'b010, 32'h2E, 32'h0);

    // Random accesses.
    for (int n = 0; n < 300; n++) begin
      rw  = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 511)) : $urandom;
      do_access(rw, rf3, ra, $urandom);
    end

    reset_mid_store(1, 32'h22, 32'h000000A5);
    reset_mid_store(2, 32'h31, 32'h0000005A);
    do_access(1'b0, 3'b010, 32'h20, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
